// File: rtl/pit_multichannel.sv
// pit_multichannel: NUM_CH down-counting interval timers with a shared
// prescaler, sticky W1C pending flags and one OR-combined interrupt line.
module pit_multichannel #(
  parameter  int NUM_CH     = 4,
  parameter  int COUNT_W    = 32,
  parameter  int PRESCALE_W = 16,
  localparam int NUM_REGS   = 2 + 3 * NUM_CH
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic [31:0]         Bus2IP_Data,
  input  logic [3:0]          Bus2IP_BE,
  input  logic [NUM_REGS-1:0] Bus2IP_RdCE,
  input  logic [NUM_REGS-1:0] Bus2IP_WrCE,
  output logic [31:0]         IP2Bus_Data,
  output logic                IP2Bus_RdAck,
  output logic                IP2Bus_WrAck,
  output logic                IP2Bus_Error,
  output logic                IP_Interupt,
  output logic [NUM_CH-1:0]   expire_pulse
);

  logic [NUM_CH-1:0][2:0]         ctrl_q, ctrl_d;
  logic [NUM_CH-1:0][COUNT_W-1:0] delay_q, delay_d;
  logic [NUM_CH-1:0][COUNT_W-1:0] count_q, count_d;
  logic [PRESCALE_W-1:0]          pre_q, pre_d;
  logic [PRESCALE_W-1:0]          pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]              pend_q, pend_d;
  logic [NUM_CH-1:0]              exp_q, exp_d;
  logic                           irq_q, irq_d;
  logic                           tick;
  logic [NUM_CH-1:0]              clr;
  logic [31:0]                    wv;
  logic [31:0]                    rdata;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic wr(input int k);
    return Bus2IP_WrCE[NUM_REGS-1-k];
  endfunction

  function automatic logic rd(input int k);
    return Bus2IP_RdCE[NUM_REGS-1-k];
  endfunction

  always_comb begin
    tick   = (pcnt_q == pre_q);
    pre_d  = pre_q;
    wv     = '0;
    if (wr(1)) begin
      wv    = merge(32'(pre_q), Bus2IP_Data, Bus2IP_BE);
      pre_d = wv[PRESCALE_W-1:0];
    end
    if (wr(1) || tick) pcnt_d = '0;
    else               pcnt_d = pcnt_q + PRESCALE_W'(1);

    clr = '0;
    if (wr(0) && Bus2IP_BE[0]) clr = Bus2IP_Data[NUM_CH-1:0];
    pend_d = pend_q & ~clr;

    ctrl_d  = ctrl_q;
    delay_d = delay_q;
    count_d = count_q;
    exp_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr(2 + 3*i)) begin
        wv        = merge(32'(ctrl_q[i]), Bus2IP_Data, Bus2IP_BE);
        ctrl_d[i] = wv[2:0];
      end
      // A DELAY write overrides any count activity on the same edge
      if (wr(3 + 3*i)) begin
        wv         = merge(32'(delay_q[i]), Bus2IP_Data, Bus2IP_BE);
        delay_d[i] = wv[COUNT_W-1:0];
        count_d[i] = wv[COUNT_W-1:0];
      end else if (tick && ctrl_d[i][0]) begin
        if (count_q[i] > COUNT_W'(1)) begin
          count_d[i] = count_q[i] - COUNT_W'(1);
        end else if (count_q[i] == COUNT_W'(1)) begin
          exp_d[i]   = 1'b1;
          count_d[i] = ctrl_d[i][2] ? delay_q[i] : '0;
        end else if (ctrl_d[i][2] && (delay_q[i] != '0)) begin
          count_d[i] = delay_q[i];
        end
      end
      if (exp_d[i] && ctrl_d[i][1]) pend_d[i] = 1'b1;
    end
    irq_d = |pend_d;
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      ctrl_q  <= '0;
      delay_q <= '0;
      count_q <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      pend_q  <= '0;
      exp_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      delay_q <= delay_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      exp_q   <= exp_d;
      irq_q   <= irq_d;
    end
  end

  // OR-mux keeps idle read data at zero without a decoder
  always_comb begin
    rdata = '0;
    if (rd(0)) rdata = rdata | 32'(pend_q);
    if (rd(1)) rdata = rdata | 32'(pre_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd(2 + 3*i)) rdata = rdata | 32'(ctrl_q[i]);
      if (rd(3 + 3*i)) rdata = rdata | 32'(delay_q[i]);
      if (rd(4 + 3*i)) rdata = rdata | 32'(count_q[i]);
    end
  end

  assign IP2Bus_Data  = rdata;
  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;
  assign IP_Interupt  = irq_q;
  assign expire_pulse = exp_q;

endmodule

// File: tb/tb_pit_multichannel.sv
// tb_pit_multichannel: directed register-level checks of the timer bank.
// Expected values are hand-computed cycle counts and register contents.
module tb_pit_multichannel;

  localparam int NR = 14;

  logic          clk;
  logic          rst;
  logic [31:0]   data;
  logic [3:0]    be;
  logic [NR-1:0] rdce;
  logic [NR-1:0] wrce;
  logic [31:0]   rdata;
  logic          rdack;
  logic          wrack;
  logic          err;
  logic          irq;
  logic [3:0]    pulse;

  int passed = 0;
  int total  = 0;
  int c;
  logic [31:0] v;

  pit_multichannel dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .Bus2IP_Data  (data),
    .Bus2IP_BE    (be),
    .Bus2IP_RdCE  (rdce),
    .Bus2IP_WrCE  (wrce),
    .IP2Bus_Data  (rdata),
    .IP2Bus_RdAck (rdack),
    .IP2Bus_WrAck (wrack),
    .IP2Bus_Error (err),
    .IP_Interupt  (irq),
    .expire_pulse (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NR-1:0] ce(input int k);
    logic [NR-1:0] r;
    r = '0;
    r[NR-1-k] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wrb(input int k, input logic [31:0] d, input logic [3:0] b);
    data = d;
    be   = b;
    wrce = ce(k);
    @(posedge clk);
    #1;
    wrce = '0;
    be   = '0;
    data = '0;
  endtask

  task automatic wr(input int k, input logic [31:0] d);
    wrb(k, d, 4'hF);
  endtask

  task automatic rd(input int k, output logic [31:0] r);
    rdce = ce(k);
    #1;
    r = rdata;
    rdce = '0;
    #1;
  endtask

  task automatic chkreg(input string tag, input int k, input logic [31:0] exp);
    logic [31:0] r;
    rd(k, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_pulse(input int ch, input int maxc, output int n);
    n = -1;
    for (int j = 1; j <= maxc; j++) begin
      @(posedge clk);
      #1;
      if (pulse[ch]) begin
        n = j;
        break;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    data = '0;
    be   = '0;
    rdce = '0;
    wrce = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset irq", 32'(irq), 32'd0);
    chk("reset pulse", 32'(pulse), 32'd0);
    chk("idle rdata", rdata, 32'd0);
    chk("error", 32'(err), 32'd0);
    chkreg("reset count0", 4, 32'd0);
    rdce = ce(0);
    #1;
    chk("rdack", 32'(rdack), 32'd1);
    rdce = '0;
    #1;

    // one-shot, no interrupt
    wr(3, 32'd10);
    wr(2, 32'd1);
    chkreg("os count 9", 4, 32'd9);
    for (int k = 8; k >= 1; k--) begin
      @(posedge clk);
      #1;
      chkreg("os count", 4, 32'(k));
      chk("os no pulse", 32'(pulse), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("os pulse", 32'(pulse), 32'd1);
    chk("os irq", 32'(irq), 32'd0);
    chkreg("os count 0", 4, 32'd0);
    @(posedge clk);
    #1;
    chk("os pulse gone", 32'(pulse), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chkreg("os hold 0", 4, 32'd0);

    // periodic reload
    wr(2, 32'd5);
    wait_pulse(0, 20, c);
    chk("rl first", 32'(c), 32'd10);
    for (int p = 0; p < 5; p++) begin
      wait_pulse(0, 20, c);
      chk("rl period", 32'(c), 32'd10);
      chkreg("rl count", 4, 32'd10);
      chk("rl irq", 32'(irq), 32'd0);
    end

    // interrupt and W1C
    wr(2, 32'd7);
    wait_pulse(0, 20, c);
    chk("irq first", 32'(c), 32'd9);
    chk("irq high", 32'(irq), 32'd1);
    chkreg("isr 1", 0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("irq sticky", 32'(irq), 32'd1);
    wr(0, 32'd1);
    chk("irq cleared", 32'(irq), 32'd0);
    chkreg("isr cleared", 0, 32'd0);
    wait_pulse(0, 20, c);
    chk("irq next", 32'(c), 32'd7);
    chk("irq again", 32'(irq), 32'd1);
    wr(2, 32'd0);
    wr(0, 32'd1);
    chkreg("isr idle", 0, 32'd0);
    chk("irq idle", 32'(irq), 32'd0);

    // prescaler on channel 1
    wr(1, 32'd3);
    wr(6, 32'd4);
    wr(5, 32'd7);
    wait_pulse(1, 40, c);
    chk("ps first", 32'(c), 32'd14);
    chkreg("ps isr", 0, 32'd2);
    chk("ps irq", 32'(irq), 32'd1);
    wait_pulse(1, 40, c);
    chk("ps period", 32'(c), 32'd16);
    chkreg("ch0 frozen", 4, 32'd10);
    wr(5, 32'd0);
    wr(0, 32'd2);
    wr(1, 32'd0);
    chkreg("ps isr clr", 0, 32'd0);

    // set beats clear; delay write beats expiry
    wr(9, 32'd3);
    wr(8, 32'd3);
    @(posedge clk);
    #1;
    chkreg("c2 count 1", 10, 32'd1);
    wr(0, 32'd4);
    chk("c2 pulse", 32'(pulse), 32'd4);
    chkreg("c2 set wins", 0, 32'd4);
    chk("c2 irq", 32'(irq), 32'd1);
    wr(8, 32'd7);
    chk("c2 zero reload", 32'(pulse), 32'd0);
    chkreg("c2 reload 3", 10, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chkreg("c2 count 1b", 10, 32'd1);
    wr(9, 32'd7);
    chk("c2 no pulse", 32'(pulse), 32'd0);
    chkreg("c2 count 7", 10, 32'd7);
    chkreg("c2 isr kept", 0, 32'd4);
    wr(8, 32'd0);
    wr(0, 32'd4);
    chkreg("c2 isr clr", 0, 32'd0);

    // reset mid-count on channel 3
    wr(12, 32'd8);
    wr(11, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    chkreg("c3 count 5", 13, 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NR; k++) begin
      chkreg("rst reg", k, 32'd0);
    end
    chk("rst irq", 32'(irq), 32'd0);
    wait_pulse(3, 12, c);
    chk("rst no pulse", 32'(c), 32'hFFFF_FFFF);

    // byte enables, read-only COUNT, CTRL masking
    wrb(12, 32'hFFFF_FFFF, 4'b0001);
    chkreg("be delay", 12, 32'h0000_00FF);
    chkreg("be count", 13, 32'h0000_00FF);
    wrb(1, 32'h1234_5678, 4'b0010);
    chkreg("be prescale", 1, 32'h0000_5600);
    wr(1, 32'd0);
    data = 32'h0000_1234;
    be   = 4'hF;
    wrce = ce(13);
    #1;
    chk("wrack", 32'(wrack), 32'd1);
    @(posedge clk);
    #1;
    wrce = '0;
    chkreg("count ro", 13, 32'h0000_00FF);
    wr(2, 32'hFFFF_FFFF);
    chkreg("ctrl mask", 2, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
